// File: rtl/card_txn_responder.sv
// card_txn_responder: card-side payment responder facing the vending controller.
// Starts a session with a CARD_IN pulse, latches the first nonzero COST,
// approves or declines it after AUTH_LAT cycles, and deducts the balance
// only when the controller confirms the vend.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   LOAD_BAL, BAL_IN    balance load (IDLE only)
//   CARD_INSERT         card present level (rising edge starts a session)
//   COST                price from controller, 0 = nothing pending
//   VEND, FAILED_TRAN   controller outcome pulses
//   INVALID_SEL         controller rejected the selection
//   CARD_IN             session-start pulse
//   VALID_TRAN          approval pulse
//   DECLINED            insufficient-funds pulse
//   BALANCE, TXN_COUNT  card balance, completed purchase count (wraps)
//   BUSY                high whenever not IDLE
module card_txn_responder #(
  parameter int unsigned BAL_W      = 8,
  parameter int unsigned AUTH_LAT   = 2,
  parameter int unsigned SESSION_TO = 15,
  parameter int unsigned VEND_TO    = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD_BAL,
  input  logic [BAL_W-1:0] BAL_IN,
  input  logic             CARD_INSERT,
  input  logic [2:0]       COST,
  input  logic             VEND,
  input  logic             FAILED_TRAN,
  input  logic             INVALID_SEL,
  output logic             CARD_IN,
  output logic             VALID_TRAN,
  output logic             DECLINED,
  output logic [BAL_W-1:0] BALANCE,
  output logic [7:0]       TXN_COUNT,
  output logic             BUSY
);

  localparam int unsigned DECLINE_TO = VEND_TO + 4;
  localparam int unsigned MAX_A      = (SESSION_TO > DECLINE_TO) ? SESSION_TO : DECLINE_TO;
  localparam int unsigned TMR_MAX    = (MAX_A > AUTH_LAT) ? MAX_A : AUTH_LAT;
  localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SESSION,
    S_AUTH,
    S_COMMIT,
    S_DECLINE
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [2:0]         cost_q, cost_d;
  logic               card_q;
  logic [BAL_W-1:0]   bal_d;
  logic [7:0]         cnt_d;
  logic               card_in_d, valid_d, declined_d, busy_d;

  // State, datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cost_q     <= '0;
      card_q     <= 1'b0;
      BALANCE    <= '0;
      TXN_COUNT  <= '0;
      CARD_IN    <= 1'b0;
      VALID_TRAN <= 1'b0;
      DECLINED   <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cost_q     <= cost_d;
      card_q     <= CARD_INSERT;
      BALANCE    <= bal_d;
      TXN_COUNT  <= cnt_d;
      CARD_IN    <= card_in_d;
      VALID_TRAN <= valid_d;
      DECLINED   <= declined_d;
      BUSY       <= busy_d;
    end
  end

  // Next-state and next-output logic; every state timer restarts at 0 on entry
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cost_d     = cost_q;
    bal_d      = BALANCE;
    cnt_d      = TXN_COUNT;
    card_in_d  = 1'b0;
    valid_d    = 1'b0;
    declined_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (LOAD_BAL) begin
          bal_d = BAL_IN;
        end else if (CARD_INSERT && !card_q) begin
          card_in_d = 1'b1;
          timer_d   = '0;
          state_d   = S_SESSION;
        end
      end

      S_SESSION: begin
        if (COST != 3'd0) begin
          cost_d  = COST;
          timer_d = '0;
          state_d = S_AUTH;
        end else if (INVALID_SEL) begin
          state_d = S_IDLE;
        end else if (timer_q == TMR_W'(SESSION_TO - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      // Decision lands on the last AUTH cycle so the pulse is visible AUTH_LAT+1 cycles after COST
      S_AUTH: begin
        if (timer_q == TMR_W'(AUTH_LAT - 1)) begin
          timer_d = '0;
          if (BALANCE >= BAL_W'(cost_q)) begin
            valid_d = 1'b1;
            state_d = S_COMMIT;
          end else begin
            declined_d = 1'b1;
            state_d    = S_DECLINE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      // VEND takes priority over FAILED_TRAN; underflow is impossible after the AUTH compare
      S_COMMIT: begin
        if (VEND) begin
          bal_d   = BALANCE - BAL_W'(cost_q);
          cnt_d   = TXN_COUNT + 8'd1;
          state_d = S_IDLE;
        end else if (FAILED_TRAN) begin
          state_d = S_IDLE;
        end else if (timer_q == TMR_W'(VEND_TO - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_DECLINE: begin
        if (FAILED_TRAN) begin
          state_d = S_IDLE;
        end else if (timer_q == TMR_W'(DECLINE_TO - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_card_txn_responder.sv
// Testbench for card_txn_responder: directed scenarios plus randomized
// transactions checked against a transaction-level balance/count model.
module tb_card_txn_responder;

  localparam int unsigned BAL_W      = 8;
  localparam int unsigned AUTH_LAT   = 2;
  localparam int unsigned SESSION_TO = 15;
  localparam int unsigned VEND_TO    = 4;
  localparam int unsigned DECLINE_TO = VEND_TO + 4;

  localparam int A_VEND = 0;
  localparam int A_FAIL = 1;
  localparam int A_NONE = 2;
  localparam int A_BOTH = 3;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             LOAD_BAL;
  logic [BAL_W-1:0] BAL_IN;
  logic             CARD_INSERT;
  logic [2:0]       COST;
  logic             VEND;
  logic             FAILED_TRAN;
  logic             INVALID_SEL;
  logic             CARD_IN;
  logic             VALID_TRAN;
  logic             DECLINED;
  logic [BAL_W-1:0] BALANCE;
  logic [7:0]       TXN_COUNT;
  logic             BUSY;

  card_txn_responder #(
    .BAL_W(BAL_W), .AUTH_LAT(AUTH_LAT), .SESSION_TO(SESSION_TO), .VEND_TO(VEND_TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .LOAD_BAL(LOAD_BAL), .BAL_IN(BAL_IN),
    .CARD_INSERT(CARD_INSERT), .COST(COST), .VEND(VEND), .FAILED_TRAN(FAILED_TRAN),
    .INVALID_SEL(INVALID_SEL), .CARD_IN(CARD_IN), .VALID_TRAN(VALID_TRAN),
    .DECLINED(DECLINED), .BALANCE(BALANCE), .TXN_COUNT(TXN_COUNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: card balance and completed-purchase count
  int m_bal = 0;
  int m_cnt = 0;

  // Edge counter and pulse monitor (sampled mid-cycle)
  int cyc_n    = 0;
  int n_card   = 0;
  int n_valid  = 0;
  int n_decl   = 0;
  int valid_at = -1;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  always @(negedge CLK) begin
    if (CARD_IN) n_card++;
    if (VALID_TRAN) begin
      n_valid++;
      valid_at = cyc_n;
    end
    if (DECLINED) n_decl++;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int v);
    LOAD_BAL = 1'b1;
    BAL_IN   = BAL_W'(v);
    cyc();
    LOAD_BAL = 1'b0;
    m_bal    = v;
    chk("load_balance", 32'(BALANCE), m_bal);
    chk("load_busy", 32'(BUSY), 0);
  endtask

  // One full session with a nonzero cost and a chosen controller response
  task automatic txn(input int cost, input int wait_c, input int act, input int dly);
    int  c0, v0, d0, e0;
    bit  ok;
    c0 = n_card;
    v0 = n_valid;
    d0 = n_decl;
    ok = (m_bal >= cost);

    CARD_INSERT = 1'b1;
    cyc();
    CARD_INSERT = 1'b0;
    chk("card_in", 32'(CARD_IN), 1);
    chk("busy_session", 32'(BUSY), 1);

    // LOAD_BAL while in a session must be ignored
    for (int i = 0; i < wait_c; i++) begin
      LOAD_BAL = 1'($urandom_range(0, 1));
      BAL_IN   = BAL_W'($urandom);
      cyc();
    end
    LOAD_BAL = 1'b0;

    COST = 3'(cost);
    cyc();
    e0 = cyc_n;
    // COST changes during AUTH must not matter
    COST = 3'($urandom_range(0, 7));
    repeat (AUTH_LAT) cyc();
    COST = 3'd0;
    chk("valid_tran", 32'(VALID_TRAN), 32'(ok));
    chk("declined", 32'(DECLINED), 32'(!ok));

    if (ok) begin
      if (act == A_NONE) begin
        repeat (VEND_TO - 1) cyc();
        chk("commit_wait_busy", 32'(BUSY), 1);
        cyc();
      end else begin
        repeat (dly % VEND_TO) cyc();
        VEND        = (act == A_VEND || act == A_BOTH);
        FAILED_TRAN = (act == A_FAIL || act == A_BOTH);
        cyc();
        VEND        = 1'b0;
        FAILED_TRAN = 1'b0;
        if (act != A_FAIL) begin
          m_bal = m_bal - cost;
          m_cnt = (m_cnt + 1) % 256;
        end
      end
    end else begin
      if (act == A_FAIL) begin
        repeat (dly % DECLINE_TO) cyc();
        FAILED_TRAN = 1'b1;
        cyc();
        FAILED_TRAN = 1'b0;
      end else begin
        // a stray VEND during decline must not deduct or end the wait
        VEND = 1'b1;
        cyc();
        VEND = 1'b0;
        repeat (DECLINE_TO - 2) cyc();
        chk("decline_wait_busy", 32'(BUSY), 1);
        cyc();
      end
    end
    chk("txn_end_busy", 32'(BUSY), 0);
    cyc();
    chk("txn_balance", 32'(BALANCE), m_bal);
    chk("txn_count", 32'(TXN_COUNT), m_cnt);
    chk("card_in_pulses", n_card - c0, 1);
    chk("valid_pulses", n_valid - v0, 32'(ok));
    chk("declined_pulses", n_decl - d0, 32'(!ok));
    if (ok) chk("valid_latency", valid_at - e0, AUTH_LAT);
  endtask

  // Session that never sees a cost: timeout or INVALID_SEL
  task automatic abandon(input bit use_invalid, input int k);
    int c0, v0, d0;
    c0 = n_card;
    v0 = n_valid;
    d0 = n_decl;
    CARD_INSERT = 1'b1;
    cyc();
    CARD_INSERT = 1'b0;
    if (use_invalid) begin
      repeat (k) cyc();
      INVALID_SEL = 1'b1;
      cyc();
      INVALID_SEL = 1'b0;
    end else begin
      repeat (SESSION_TO - 1) cyc();
      chk("session_wait_busy", 32'(BUSY), 1);
      cyc();
    end
    chk("abandon_busy", 32'(BUSY), 0);
    cyc();
    chk("abandon_card_in", n_card - c0, 1);
    chk("abandon_valid", n_valid - v0, 0);
    chk("abandon_declined", n_decl - d0, 0);
    chk("abandon_balance", 32'(BALANCE), m_bal);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc();
    cyc();
    RESET = 1'b0;
    m_bal = 0;
    m_cnt = 0;
  endtask

  initial begin
    int v0, d0, b;
    RESET       = 1'b1;
    LOAD_BAL    = 1'b0;
    BAL_IN      = '0;
    CARD_INSERT = 1'b0;
    COST        = 3'd0;
    VEND        = 1'b0;
    FAILED_TRAN = 1'b0;
    INVALID_SEL = 1'b0;

    // Reset state
    do_reset();
    chk("rst_balance", 32'(BALANCE), 0);
    chk("rst_count", 32'(TXN_COUNT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_pulses", 32'({CARD_IN, VALID_TRAN, DECLINED}), 0);

    // Load and approved purchase
    load(20);
    chk("load_count", 32'(TXN_COUNT), 0);
    txn(2, 3, A_VEND, 1);

    // Insufficient funds
    load(4);
    txn(5, 0, A_FAIL, 0);
    txn(5, 2, A_NONE, 0);

    // Abandoned sessions
    abandon(1'b0, 0);
    abandon(1'b1, 3);
    abandon(1'b1, 0);

    // Commit edge cases
    load(30);
    txn(3, 1, A_FAIL, 2);
    txn(3, 0, A_BOTH, 0);
    txn(3, 2, A_NONE, 0);
    txn(7, 14, A_VEND, 3);

    // Reset on the deciding AUTH cycle: no approval, balance cleared
    load(50);
    v0 = n_valid;
    d0 = n_decl;
    CARD_INSERT = 1'b1;
    cyc();
    CARD_INSERT = 1'b0;
    COST = 3'd3;
    cyc();
    repeat (AUTH_LAT - 1) cyc();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    COST  = 3'd0;
    m_bal = 0;
    m_cnt = 0;
    chk("rst_auth_busy", 32'(BUSY), 0);
    chk("rst_auth_balance", 32'(BALANCE), m_bal);
    chk("rst_auth_valid", 32'(VALID_TRAN), 0);
    repeat (6) cyc();
    chk("rst_auth_no_valid", n_valid - v0, 0);
    chk("rst_auth_no_decl", n_decl - d0, 0);
    chk("rst_auth_idle", 32'(BUSY), 0);

    // LOAD_BAL beats CARD_INSERT; held CARD_INSERT does not start a session
    LOAD_BAL    = 1'b1;
    BAL_IN      = BAL_W'(9);
    CARD_INSERT = 1'b1;
    cyc();
    LOAD_BAL = 1'b0;
    m_bal    = 9;
    chk("prio_balance", 32'(BALANCE), m_bal);
    chk("prio_busy", 32'(BUSY), 0);
    chk("prio_card_in", 32'(CARD_IN), 0);
    cyc();
    cyc();
    chk("held_busy", 32'(BUSY), 0);
    chk("held_card_in", 32'(CARD_IN), 0);
    CARD_INSERT = 1'b0;
    cyc();

    // 256 purchases wrap the count back to zero
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (m_bal < 7) load(255);
      txn($urandom_range(1, 7), 0, A_VEND, 1);
    end
    chk("count_wrap", 32'(TXN_COUNT), 0);

    // Randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, 12);
        load(b);
      end
      if ($urandom_range(0, 9) == 0)
        abandon($urandom_range(0, 1) == 1, $urandom_range(0, 13));
      else
        txn($urandom_range(1, 7), $urandom_range(0, 14), $urandom_range(0, 3),
            $urandom_range(0, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_txn_responder.md
Name: card_txn_responder

Overview:
- Card-side payment responder on the far end of the vending machine's transaction interface.
- Issues the CARD_IN session pulse and watches COST from the vending controller.
- Checks COST against a stored card balance and answers with a VALID_TRAN pulse after a fixed authorization latency.
- Deducts the balance only when the controller confirms with VEND; sits between the user/card model and vending_machine in the top level.

Parameters:
- BAL_W, 8, width of balance register and BAL_IN/BALANCE ports
- AUTH_LAT, 2, cycles from COST sampled to VALID_TRAN; legal range 1..3 (controller abandons transact after 5 cycles)
- SESSION_TO, 15, max cycles in SESSION waiting for nonzero COST before abandoning
- VEND_TO, 4, max cycles in COMMIT waiting for VEND or FAILED_TRAN

Ports:
- CLK  input  1  clock
- RESET  input  1  synchronous active-high reset
- LOAD_BAL  input  1  load BAL_IN into balance; honoured only in IDLE
- BAL_IN  input  BAL_W  new balance value
- CARD_INSERT  input  1  user inserts card (level)
- COST  input  3  price from vending controller; 0 = no transaction pending
- VEND  input  1  controller dispensed item (1-cycle pulse)
- FAILED_TRAN  input  1  controller transaction timed out (1-cycle pulse)
- INVALID_SEL  input  1  controller rejected selection (1-cycle pulse)
- CARD_IN  output  1  session-start pulse to controller
- VALID_TRAN  output  1  payment approved, 1-cycle pulse
- DECLINED  output  1  insufficient-funds pulse, 1 cycle
- BALANCE  output  BAL_W  current card balance
- TXN_COUNT  output  8  completed (VEND-confirmed) purchases, wraps 255->0
- BUSY  output  1  high in every state except IDLE

Behaviour:
- Reset, synchronous, overrides all inputs in the same edge: state=IDLE, BALANCE=0, TXN_COUNT=0, all pulse outputs 0, all counters 0. Reset mid-transaction discards the pending cost and makes no deduction.
- All outputs registered.
- IDLE:
  - LOAD_BAL=1: BALANCE<=BAL_IN next cycle. LOAD_BAL has priority over CARD_INSERT in the same cycle; no session starts.
  - CARD_INSERT=1 (and no LOAD_BAL): CARD_IN=1 for exactly one cycle, go to SESSION. CARD_INSERT must drop and re-rise before another session; a held level does not re-trigger.
- SESSION: timer counts cycles.
  - COST!=0: latch COST into cost_q, go to AUTH.
  - INVALID_SEL: go to IDLE.
  - Timer reaches SESSION_TO: go to IDLE. Covers controller key-entry timeout; no output.
- AUTH: waits AUTH_LAT cycles, then compares BALANCE >= zero-extended cost_q.
  - True: VALID_TRAN=1 for one cycle (asserted AUTH_LAT+1 cycles after the first cycle COST!=0 was seen), go to COMMIT.
  - False: DECLINED=1 one cycle, go to DECLINE.
  - COST changes during AUTH: ignored; cost_q is used.
- COMMIT:
  - VEND: BALANCE<=BALANCE-cost_q, TXN_COUNT+=1, go to IDLE.
  - FAILED_TRAN: no deduction, go to IDLE.
  - VEND_TO cycles with neither: go to IDLE, no deduction.
  - VEND and FAILED_TRAN in the same cycle: VEND wins.
- DECLINE: VALID_TRAN is never asserted. Go to IDLE on FAILED_TRAN, or after VEND_TO+4 cycles.
- Arithmetic: subtraction cannot underflow because it is gated by the AUTH compare. BALANCE never changes outside the LOAD_BAL path and the COMMIT VEND path.
- LOAD_BAL outside IDLE: ignored.
- CARD_INSERT outside IDLE: ignored, but still tracked for edge detection.

Test Plan:
- Reset then load: LOAD_BAL with BAL_IN=20 in IDLE -> BALANCE=20 next cycle, BUSY=0, TXN_COUNT=0.
- Approved purchase: BALANCE=20, CARD_INSERT, COST=2 appears, VEND one cycle after VALID_TRAN -> CARD_IN pulse; VALID_TRAN exactly 3 cycles after COST!=0 (AUTH_LAT=2); BALANCE=18; TXN_COUNT=1; IDLE.
- Insufficient funds: BALANCE=4, COST=5 -> DECLINED pulse, no VALID_TRAN, FAILED_TRAN returns to IDLE, BALANCE stays 4.
- Abandoned session: CARD_INSERT, COST stays 0 for 15 cycles -> IDLE at cycle 15, no pulses. Repeat with an INVALID_SEL pulse -> IDLE next cycle.
- Commit edge cases: after VALID_TRAN, FAILED_TRAN -> no deduction; VEND+FAILED_TRAN together -> deduction applied; neither for 4 cycles -> IDLE, balance unchanged.
- Reset mid-AUTH, plus priority/wrap: RESET during AUTH -> IDLE, no VALID_TRAN, BALANCE=0. LOAD_BAL and CARD_INSERT together -> load only. 256 purchases -> TXN_COUNT wraps to 0.
